// File: rtl/rv_hazard_unit.sv
// Hazard detection and operand forwarding for the RV32I pipeline: a shift-register
// scoreboard of in-flight destinations feeds forwarding, load-use stalls and squashes.
module rv_hazard_unit #(
    parameter int XLEN       = 32,
    parameter int RF_AW      = 5,
    parameter int NSTG       = 3,
    parameter int ALU_READY  = 1,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 16,
    parameter int PW         = $clog2(NSTG + 1)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 dec_valid,
    input  logic [RF_AW-1:0]     dec_rs1_addr,
    input  logic [RF_AW-1:0]     dec_rs2_addr,
    input  logic                 dec_rs1_used,
    input  logic                 dec_rs2_used,
    input  logic [RF_AW-1:0]     dec_rd_addr,
    input  logic                 dec_rd_wr,
    input  logic                 dec_is_load,
    input  logic [XLEN-1:0]      rf_rs1_data,
    input  logic [XLEN-1:0]      rf_rs2_data,
    input  logic [NSTG*XLEN-1:0] stg_data,
    input  logic                 pipe_hold,
    input  logic                 redirect_valid,
    input  logic [PW-1:0]        redirect_pos,
    output logic [XLEN-1:0]      fwd_rs1_data,
    output logic [XLEN-1:0]      fwd_rs2_data,
    output logic [PW-1:0]        fwd_rs1_sel,
    output logic [PW-1:0]        fwd_rs2_sel,
    output logic                 stall_dec,
    output logic                 flush_dec,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    logic [NSTG-1:0]  sb_v;
    logic [NSTG-1:0]  sb_wr;
    logic [NSTG-1:0]  sb_ld;
    logic [RF_AW-1:0] sb_rd [NSTG];

    logic [RF_AW-1:0] src_addr [2];
    logic             src_used [2];
    logic [XLEN-1:0]  src_rf   [2];
    logic             hit      [2];
    logic             rdy      [2];
    logic [PW-1:0]    fsel     [2];
    logic [XLEN-1:0]  fdata    [2];
    logic             hz;
    logic [NSTG-1:0]  kill;
    logic             stall_evt;

    assign src_addr[0] = dec_rs1_addr;
    assign src_addr[1] = dec_rs2_addr;
    assign src_used[0] = dec_rs1_used;
    assign src_used[1] = dec_rs2_used;
    assign src_rf[0]   = rf_rs1_data;
    assign src_rf[1]   = rf_rs2_data;

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            hit[s]   = 1'b0;
            rdy[s]   = 1'b0;
            fsel[s]  = PW'(NSTG);
            fdata[s] = src_rf[s];
            for (int p = NSTG - 1; p >= 0; p--) begin
                if (sb_v[p] && sb_wr[p] && (sb_rd[p] == src_addr[s]) &&
                    (src_addr[s] != '0) && src_used[s]) begin
                    hit[s]   = 1'b1;
                    rdy[s]   = sb_ld[p] ? (p >= LOAD_READY) : (p >= ALU_READY);
                    fsel[s]  = PW'(p);
                    fdata[s] = stg_data[p*XLEN +: XLEN];
                end
            end
            // A match that is not ready yet stalls; the operand falls back to the RF.
            if (hit[s] && !rdy[s]) begin
                fsel[s]  = PW'(NSTG);
                fdata[s] = src_rf[s];
            end
        end
    end

    assign fwd_rs1_sel  = fsel[0];
    assign fwd_rs2_sel  = fsel[1];
    assign fwd_rs1_data = fdata[0];
    assign fwd_rs2_data = fdata[1];

    assign hz        = (hit[0] & ~rdy[0]) | (hit[1] & ~rdy[1]);
    assign stall_dec = rstn & ((dec_valid & hz) | pipe_hold);
    // Redirect is only taken while the pipe moves; the requester holds it through a freeze.
    assign flush_dec = rstn & redirect_valid & ~pipe_hold;
    assign stall_evt = dec_valid & hz & ~pipe_hold & ~flush_dec;

    always_comb begin
        for (int p = 0; p < NSTG; p++) begin
            kill[p] = flush_dec && (PW'(p) < redirect_pos);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sb_v      <= '0;
            sb_wr     <= '0;
            sb_ld     <= '0;
            for (int p = 0; p < NSTG; p++) begin
                sb_rd[p] <= '0;
            end
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!pipe_hold) begin
            for (int p = NSTG - 1; p >= 1; p--) begin
                sb_v[p]  <= sb_v[p-1] & ~kill[p-1];
                sb_wr[p] <= sb_wr[p-1];
                sb_ld[p] <= sb_ld[p-1];
                sb_rd[p] <= sb_rd[p-1];
            end
            sb_v[0]  <= dec_valid & ~hz & ~flush_dec;
            sb_wr[0] <= dec_rd_wr;
            sb_ld[0] <= dec_is_load;
            sb_rd[0] <= dec_rd_addr;
            if (stall_evt && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_dec && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv_hazard_unit.sv
// Directed bench for rv_hazard_unit: forwarding, load-use stalls, redirect squash,
// freeze behaviour, counter saturation and mid-stream reset.
module tb_rv_hazard_unit;

    localparam int XLEN  = 32;
    localparam int RF_AW = 5;
    localparam int NSTG  = 3;
    localparam int CNT_W = 4;
    localparam int PW    = $clog2(NSTG + 1);

    localparam logic [XLEN-1:0] S0  = 32'hAAAA0000;
    localparam logic [XLEN-1:0] S1  = 32'hBBBB0001;
    localparam logic [XLEN-1:0] S2  = 32'hCCCC0002;
    localparam logic [XLEN-1:0] RF1 = 32'h11111111;
    localparam logic [XLEN-1:0] RF2 = 32'h22222222;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 dec_valid;
    logic [RF_AW-1:0]     dec_rs1_addr;
    logic [RF_AW-1:0]     dec_rs2_addr;
    logic                 dec_rs1_used;
    logic                 dec_rs2_used;
    logic [RF_AW-1:0]     dec_rd_addr;
    logic                 dec_rd_wr;
    logic                 dec_is_load;
    logic [XLEN-1:0]      rf_rs1_data;
    logic [XLEN-1:0]      rf_rs2_data;
    logic [NSTG*XLEN-1:0] stg_data;
    logic                 pipe_hold;
    logic                 redirect_valid;
    logic [PW-1:0]        redirect_pos;
    logic [XLEN-1:0]      fwd_rs1_data;
    logic [XLEN-1:0]      fwd_rs2_data;
    logic [PW-1:0]        fwd_rs1_sel;
    logic [PW-1:0]        fwd_rs2_sel;
    logic                 stall_dec;
    logic                 flush_dec;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;

    int errors = 0;
    int checks = 0;

    rv_hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .dec_valid      (dec_valid),
        .dec_rs1_addr   (dec_rs1_addr),
        .dec_rs2_addr   (dec_rs2_addr),
        .dec_rs1_used   (dec_rs1_used),
        .dec_rs2_used   (dec_rs2_used),
        .dec_rd_addr    (dec_rd_addr),
        .dec_rd_wr      (dec_rd_wr),
        .dec_is_load    (dec_is_load),
        .rf_rs1_data    (rf_rs1_data),
        .rf_rs2_data    (rf_rs2_data),
        .stg_data       (stg_data),
        .pipe_hold      (pipe_hold),
        .redirect_valid (redirect_valid),
        .redirect_pos   (redirect_pos),
        .fwd_rs1_data   (fwd_rs1_data),
        .fwd_rs2_data   (fwd_rs2_data),
        .fwd_rs1_sel    (fwd_rs1_sel),
        .fwd_rs2_sel    (fwd_rs2_sel),
        .stall_dec      (stall_dec),
        .flush_dec      (flush_dec),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic drive_dec(input logic v, input logic [RF_AW-1:0] rs1, input logic u1,
                             input logic [RF_AW-1:0] rs2, input logic u2,
                             input logic [RF_AW-1:0] rd, input logic wr, input logic ld);
        dec_valid    = v;
        dec_rs1_addr = rs1;
        dec_rs1_used = u1;
        dec_rs2_addr = rs2;
        dec_rs2_used = u2;
        dec_rd_addr  = rd;
        dec_rd_wr    = wr;
        dec_is_load  = ld;
    endtask

    task automatic do_reset;
        rstn           = 1'b0;
        pipe_hold      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pos   = '0;
        drive_dec(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        tick;
        rstn = 1'b1;
    endtask

    task automatic test_reset;
        rstn           = 1'b0;
        rf_rs1_data    = RF1;
        rf_rs2_data    = RF2;
        stg_data       = {S2, S1, S0};
        pipe_hold      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pos   = 2'd2;
        drive_dec(1, 5, 1, 6, 1, 7, 1, 0);
        tick;
        #1;
        checks++;
        if (stall_dec !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall_dec); end
        checks++;
        if (flush_dec !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0b want 0", flush_dec); end
        tick;
        pipe_hold      = 1'b0;
        redirect_valid = 1'b0;
        rstn           = 1'b1;
        #1;
        checks++;
        if (fwd_rs1_sel !== 2'd3) begin errors++; $display("FAIL reset_sel1: got %0d want 3", fwd_rs1_sel); end
        checks++;
        if (fwd_rs2_sel !== 2'd3) begin errors++; $display("FAIL reset_sel2: got %0d want 3", fwd_rs2_sel); end
        checks++;
        if (fwd_rs1_data !== RF1) begin errors++; $display("FAIL reset_data1: got %h want %h", fwd_rs1_data, RF1); end
        checks++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_alu_dep;
        do_reset;
        drive_dec(1, 0, 0, 0, 0, 5, 1, 0);          // addi x5
        #1;
        checks++;
        if (stall_dec !== 1'b0) begin errors++; $display("FAIL alu_issue_stall: got %0b want 0", stall_dec); end
        tick;
        drive_dec(1, 5, 1, 5, 1, 6, 1, 0);          // add x6,x5,x5 while addi is at p=0
        #1;
        checks++;
        if (stall_dec !== 1'b1) begin errors++; $display("FAIL alu_p0_stall: got %0b want 1", stall_dec); end
        tick;
        #1;
        checks++;
        if (stall_dec !== 1'b0) begin errors++; $display("FAIL alu_release_stall: got %0b want 0", stall_dec); end
        checks++;
        if (fwd_rs1_sel !== 2'd1 || fwd_rs2_sel !== 2'd1) begin
            errors++; $display("FAIL alu_sel: got %0d/%0d want 1/1", fwd_rs1_sel, fwd_rs2_sel);
        end
        checks++;
        if (fwd_rs1_data !== S1 || fwd_rs2_data !== S1) begin
            errors++; $display("FAIL alu_data: got %h/%h want %h", fwd_rs1_data, fwd_rs2_data, S1);
        end
        checks++;
        if (stall_cnt !== 4'd1) begin errors++; $display("FAIL alu_stall_cnt: got %0d want 1", stall_cnt); end
    endtask

    task automatic test_load_use;
        do_reset;
        drive_dec(1, 2, 1, 0, 0, 7, 1, 1);          // lw x7,0(x2)
        tick;
        drive_dec(1, 7, 1, 1, 1, 8, 1, 0);          // sub x8,x7,x1
        #1;
        checks++;
        if (stall_dec !== 1'b1) begin errors++; $display("FAIL lu_stall1: got %0b want 1", stall_dec); end
        tick;
        #1;
        checks++;
        if (stall_dec !== 1'b1) begin errors++; $display("FAIL lu_stall2: got %0b want 1", stall_dec); end
        tick;
        #1;
        checks++;
        if (stall_dec !== 1'b0) begin errors++; $display("FAIL lu_release: got %0b want 0", stall_dec); end
        checks++;
        if (fwd_rs1_sel !== 2'd2 || fwd_rs1_data !== S2) begin
            errors++; $display("FAIL lu_fwd1: got sel %0d data %h want sel 2 data %h", fwd_rs1_sel, fwd_rs1_data, S2);
        end
        checks++;
        if (fwd_rs2_sel !== 2'd3 || fwd_rs2_data !== RF2) begin
            errors++; $display("FAIL lu_fwd2: got sel %0d data %h want sel 3 data %h", fwd_rs2_sel, fwd_rs2_data, RF2);
        end
        checks++;
        if (stall_cnt !== 4'd2) begin errors++; $display("FAIL lu_stall_cnt: got %0d want 2", stall_cnt); end
        tick;
        drive_dec(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        drive_dec(1, 8, 1, 7, 1, 9, 1, 0);          // sub now at p=1, lw retired
        #1;
        checks++;
        if (fwd_rs1_sel !== 2'd1 || fwd_rs2_sel !== 2'd3 || stall_dec !== 1'b0) begin
            errors++; $display("FAIL lu_after: got sel %0d/%0d stall %0b want 1/3 stall 0",
                               fwd_rs1_sel, fwd_rs2_sel, stall_dec);
        end
    endtask

    task automatic test_youngest_x0;
        do_reset;
        drive_dec(1, 0, 0, 0, 0, 3, 1, 0);          // older x3
        tick;
        drive_dec(1, 0, 0, 0, 0, 3, 1, 0);          // younger x3
        tick;
        drive_dec(1, 0, 0, 0, 0, 0, 1, 0);          // writes x0
        tick;
        drive_dec(1, 3, 1, 0, 1, 4, 1, 0);
        #1;
        checks++;
        if (fwd_rs1_sel !== 2'd1 || fwd_rs1_data !== S1) begin
            errors++; $display("FAIL young_x3: got sel %0d data %h want sel 1 data %h", fwd_rs1_sel, fwd_rs1_data, S1);
        end
        checks++;
        if (fwd_rs2_sel !== 2'd3 || fwd_rs2_data !== RF2) begin
            errors++; $display("FAIL young_x0: got sel %0d data %h want sel 3 data %h", fwd_rs2_sel, fwd_rs2_data, RF2);
        end
        checks++;
        if (stall_dec !== 1'b0) begin errors++; $display("FAIL young_stall: got %0b want 0", stall_dec); end
    endtask

    task automatic test_redirect;
        do_reset;
        drive_dec(1, 0, 0, 0, 0, 10, 1, 0);
        tick;
        drive_dec(1, 0, 0, 0, 0, 11, 1, 0);
        tick;
        drive_dec(1, 0, 0, 0, 0, 12, 1, 1);         // load at p=0 on the redirect cycle
        tick;
        drive_dec(1, 12, 1, 0, 0, 13, 1, 0);
        redirect_valid = 1'b1;
        redirect_pos   = 2'd2;
        #1;
        checks++;
        if (flush_dec !== 1'b1) begin errors++; $display("FAIL rd_flush: got %0b want 1", flush_dec); end
        tick;
        redirect_valid = 1'b0;
        drive_dec(1, 11, 1, 12, 1, 13, 1, 0);
        #1;
        checks++;
        if (fwd_rs1_sel !== 2'd3 || fwd_rs2_sel !== 2'd3 || stall_dec !== 1'b0) begin
            errors++; $display("FAIL rd_cleared: got sel %0d/%0d stall %0b want 3/3 stall 0",
                               fwd_rs1_sel, fwd_rs2_sel, stall_dec);
        end
        checks++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
            errors++; $display("FAIL rd_cnt: got flush %0d stall %0d want 1/0", flush_cnt, stall_cnt);
        end
        tick;
        drive_dec(1, 0, 0, 0, 0, 10, 1, 0);
        tick;
        drive_dec(1, 0, 0, 0, 0, 11, 1, 0);
        tick;
        drive_dec(1, 0, 0, 0, 0, 12, 1, 0);
        tick;
        drive_dec(0, 0, 0, 0, 0, 0, 0, 0);
        redirect_valid = 1'b1;
        redirect_pos   = 2'd1;                      // x11 at p=1 survives
        tick;
        redirect_valid = 1'b0;
        drive_dec(1, 11, 1, 12, 1, 0, 0, 0);
        #1;
        checks++;
        if (fwd_rs1_sel !== 2'd2 || fwd_rs1_data !== S2) begin
            errors++; $display("FAIL rd_survivor: got sel %0d data %h want sel 2 data %h", fwd_rs1_sel, fwd_rs1_data, S2);
        end
        checks++;
        if (fwd_rs2_sel !== 2'd3) begin errors++; $display("FAIL rd_killed: got sel %0d want 3", fwd_rs2_sel); end
        checks++;
        if (flush_cnt !== 4'd2) begin errors++; $display("FAIL rd_flush_cnt2: got %0d want 2", flush_cnt); end
    endtask

    task automatic test_pipe_hold;
        do_reset;
        drive_dec(1, 0, 0, 0, 0, 7, 1, 1);          // lw x7
        tick;
        drive_dec(1, 7, 1, 0, 0, 8, 1, 0);
        #1;
        checks++;
        if (stall_dec !== 1'b1) begin errors++; $display("FAIL hold_pre_stall: got %0b want 1", stall_dec); end
        tick;
        pipe_hold      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pos   = 2'd3;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (stall_dec !== 1'b1 || flush_dec !== 1'b0) begin
                errors++; $display("FAIL hold_cycle%0d: got stall %0b flush %0b want 1/0", i, stall_dec, flush_dec);
            end
            tick;
        end
        pipe_hold = 1'b0;
        #1;
        checks++;
        if (stall_dec !== 1'b1 || flush_dec !== 1'b1) begin
            errors++; $display("FAIL hold_release: got stall %0b flush %0b want 1/1", stall_dec, flush_dec);
        end
        checks++;
        if (stall_cnt !== 4'd1 || flush_cnt !== 4'd0) begin
            errors++; $display("FAIL hold_frozen_cnt: got %0d/%0d want 1/0", stall_cnt, flush_cnt);
        end
        tick;
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (stall_dec !== 1'b0 || fwd_rs1_sel !== 2'd3) begin
            errors++; $display("FAIL hold_after_flush: got stall %0b sel %0d want 0/3", stall_dec, fwd_rs1_sel);
        end
        checks++;
        if (stall_cnt !== 4'd1 || flush_cnt !== 4'd1) begin
            errors++; $display("FAIL hold_after_cnt: got %0d/%0d want 1/1", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_saturation_reset;
        do_reset;
        for (int i = 0; i < 10; i++) begin
            drive_dec(1, 0, 0, 0, 0, 7, 1, 1);
            tick;
            drive_dec(1, 7, 1, 0, 0, 0, 0, 0);
            tick;
            tick;
            tick;
            if (i == 6) begin
                checks++;
                if (stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_mid: got %0d want 14", stall_cnt); end
            end
        end
        checks++;
        if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_final: got %0d want 15", stall_cnt); end
        drive_dec(0, 0, 0, 0, 0, 0, 0, 0);
        redirect_valid = 1'b1;
        redirect_pos   = 2'd0;
        tick;
        redirect_valid = 1'b0;
        drive_dec(1, 0, 0, 0, 0, 7, 1, 1);
        tick;
        drive_dec(1, 7, 1, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (stall_dec !== 1'b1 || flush_cnt !== 4'd1) begin
            errors++; $display("FAIL mid_pre: got stall %0b flush_cnt %0d want 1/1", stall_dec, flush_cnt);
        end
        rstn           = 1'b0;
        pipe_hold      = 1'b1;
        redirect_valid = 1'b1;
        #1;
        checks++;
        if (stall_dec !== 1'b0 || flush_dec !== 1'b0) begin
            errors++; $display("FAIL mid_rst_outs: got %0b/%0b want 0/0", stall_dec, flush_dec);
        end
        tick;
        rstn           = 1'b1;
        pipe_hold      = 1'b0;
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            errors++; $display("FAIL mid_rst_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        checks++;
        if (fwd_rs1_sel !== 2'd3 || fwd_rs1_data !== RF1 || stall_dec !== 1'b0) begin
            errors++; $display("FAIL mid_rst_fwd: got sel %0d data %h stall %0b want 3 %h 0",
                               fwd_rs1_sel, fwd_rs1_data, stall_dec, RF1);
        end
    endtask

    initial begin
        test_reset;
        test_alu_dep;
        test_load_use;
        test_youngest_x0;
        test_redirect;
        test_pipe_hold;
        test_saturation_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
